// File: rtl/conf_register_bank.sv
// conf_register_bank: NUM_REGS configuration registers at BASE_ADDR..BASE_ADDR+NUM_REGS-1
// on the simple write interface, with per-register write pulses and a registered readback port.
// Latency: si_ack is combinational; data/wr_pulse update one cycle after the request; rd_* one cycle after rd_req.
// Backpressure: none; every request is accepted or missed in the cycle it is presented.
// Ports: clk, rst (async, active-high); si_addr/si_data/si_rdy/si_ack write port; commit strobe;
//        rd_req/rd_addr -> rd_data/rd_valid/rd_err readback; data packed live values; wr_pulse per-register strobes.
// Option: define CONF_REGISTER_BANK_SHADOW_EN for shadowed writes committed by commit or a hit at BASE_ADDR+NUM_REGS.
module conf_register_bank #(
  parameter int                               ADDR_WIDTH   = 16,
  parameter int                               DATA_WIDTH   = 16,
  parameter int                               NUM_REGS     = 4,
  parameter logic [ADDR_WIDTH-1:0]            BASE_ADDR    = 16'h0010,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0,
  parameter logic [NUM_REGS-1:0]              RO_MASK      = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          si_addr,
  input  logic [DATA_WIDTH-1:0]          si_data,
  input  logic                           si_rdy,
  output logic                           si_ack,
  input  logic                           commit,
  input  logic                           rd_req,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_valid,
  output logic                           rd_err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] data,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IW   = ADDR_WIDTH + 1;
  localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Offsets carry one extra bit: an address below BASE_ADDR wraps to a huge
  // value, and BASE_ADDR near the top of the space cannot wrap back into range.
  logic [IW-1:0]       wr_off, rd_off;
  logic [IDXW-1:0]     wr_idx, rd_idx;
  logic                wr_in_range, rd_in_range;
  logic                hit;
  logic [NUM_REGS-1:0] wr_onehot;

  assign wr_off      = {1'b0, si_addr} - {1'b0, BASE_ADDR};
  assign rd_off      = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
  assign wr_idx      = wr_off[IDXW-1:0];
  assign rd_idx      = rd_off[IDXW-1:0];
  assign wr_in_range = (wr_off < IW'(NUM_REGS));
  assign rd_in_range = (rd_off < IW'(NUM_REGS));
  assign hit         = si_rdy && wr_in_range && !RO_MASK[wr_idx];
  assign wr_onehot   = hit ? (NUM_REGS'(1) << wr_idx) : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_data
      assign data[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
  endgenerate

`ifdef CONF_REGISTER_BANK_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0]   pend;
  logic                  cfg_hit;
  logic                  do_commit;

  // The address just past the bank is a write-only commit trigger.
  assign cfg_hit   = si_rdy && (wr_off == IW'(NUM_REGS));
  assign do_commit = commit || cfg_hit;
  assign si_ack    = hit || cfg_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        regs[i]   <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
      pend     <= '0;
      wr_pulse <= '0;
    end else begin
      if (hit) shadow[wr_idx] <= si_data;
      if (do_commit) begin
        // A write landing on the commit edge bypasses the shadow so it is included.
        for (int i = 0; i < NUM_REGS; i++)
          regs[i] <= wr_onehot[i] ? si_data : shadow[i];
        wr_pulse <= pend | wr_onehot;
        pend     <= '0;
      end else begin
        wr_pulse <= '0;
        pend     <= pend | wr_onehot;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_view;
  assign rd_view = shadow[rd_idx];
`else
  logic unused_commit;
  assign unused_commit = commit;
  assign si_ack        = hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      wr_pulse <= '0;
    end else begin
      if (hit) regs[wr_idx] <= si_data;
      wr_pulse <= wr_onehot;
    end
  end

  logic [DATA_WIDTH-1:0] rd_view;
  assign rd_view = regs[rd_idx];
`endif

  // Readback samples the pre-edge value, so a same-edge write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (rd_in_range) begin
          rd_data <= rd_view;
          rd_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

endmodule
